// File: rtl/maze_score_keeper_if.sv
// Game-side bus of the maze score keeper: round control and position in, BCD scores out.
interface maze_score_keeper_if;
    logic [1:0]  state;
    logic [2:0]  level;
    logic [4:0]  x_index;
    logic [4:0]  y_index;
    logic        arrived;
    logic [15:0] steps_bcd;
    logic [15:0] secs_bcd;
    logic [15:0] best_bcd;
    logic        new_record;
    logic        running;

    modport master (
        output state, level, x_index, y_index, arrived,
        input  steps_bcd, secs_bcd, best_bcd, new_record, running
    );

    modport slave (
        input  state, level, x_index, y_index, arrived,
        output steps_bcd, secs_bcd, best_bcd, new_record, running
    );
endinterface

// File: rtl/maze_score_keeper.sv
// Maze round scoring: BCD step and second counters, plus a per-level best-steps table.
// LEVELS may be at most 8 because level is a 3-bit index.
module maze_score_keeper #(
    parameter int TICK_DIV = 100_000_000,
    parameter int LEVELS   = 8
) (
    input  logic                clk,
    input  logic                rst_sys,
    maze_score_keeper_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, COMMIT, HOLD} fsm_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    // Four-digit BCD increment that sticks at 9999 instead of wrapping.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    fsm_t          state_q, state_d;
    logic [15:0]   steps_q, steps_d;
    logic [15:0]   secs_q, secs_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    lvl_q, lvl_d;
    logic [4:0]    prev_x_q, prev_x_d;
    logic [4:0]    prev_y_q, prev_y_d;
    logic          arr_q, arr_d;
    logic          new_record_q, new_record_d;
    logic          running_q, running_d;
    logic [15:0]   best_q [LEVELS];
    logic [15:0]   best_d [LEVELS];
    logic [LEVELS-1:0] valid_q, valid_d;
    logic          enter;

    always_comb begin
        state_d      = state_q;
        steps_d      = steps_q;
        secs_d       = secs_q;
        tick_d       = tick_q;
        lvl_d        = lvl_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        new_record_d = new_record_q;
        best_d       = best_q;
        valid_d      = valid_q;
        arr_d        = bus.arrived;
        enter        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.state == 2'b01) begin
                    enter = 1'b1;
                end
            end
            RUN: begin
                if ({bus.x_index, bus.y_index} != {prev_x_q, prev_y_q}) begin
                    steps_d  = bcd_inc(steps_q);
                    prev_x_d = bus.x_index;
                    prev_y_d = bus.y_index;
                end
                if (tick_q == TICK_MAX) begin
                    tick_d = '0;
                    secs_d = bcd_inc(secs_q);
                end else begin
                    tick_d = tick_q + 1'b1;
                end
                if (bus.arrived && !arr_q) begin
                    state_d = COMMIT;
                end else if (bus.state != 2'b01) begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                // BCD digits order the same way as unsigned binary, so a plain compare works.
                if (!valid_q[lvl_q] || (steps_q < best_q[lvl_q])) begin
                    best_d[lvl_q]  = steps_q;
                    valid_d[lvl_q] = 1'b1;
                    new_record_d   = 1'b1;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.state == 2'b01) begin
                    enter = 1'b1;
                end else if (bus.state != 2'b10) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter) begin
            state_d      = RUN;
            steps_d      = '0;
            secs_d       = '0;
            tick_d       = '0;
            new_record_d = 1'b0;
            lvl_d        = bus.level;
            prev_x_d     = bus.x_index;
            prev_y_d     = bus.y_index;
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            state_q      <= IDLE;
            steps_q      <= '0;
            secs_q       <= '0;
            tick_q       <= '0;
            lvl_q        <= '0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            arr_q        <= 1'b0;
            new_record_q <= 1'b0;
            running_q    <= 1'b0;
            valid_q      <= '0;
            for (int i = 0; i < LEVELS; i++) begin
                best_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            steps_q      <= steps_d;
            secs_q       <= secs_d;
            tick_q       <= tick_d;
            lvl_q        <= lvl_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            arr_q        <= arr_d;
            new_record_q <= new_record_d;
            running_q    <= running_d;
            valid_q      <= valid_d;
            best_q       <= best_d;
        end
    end

    assign bus.steps_bcd  = steps_q;
    assign bus.secs_bcd   = secs_q;
    assign bus.new_record = new_record_q;
    assign bus.running    = running_q;
    assign bus.best_bcd   = valid_q[bus.level] ? best_q[bus.level] : 16'h0000;
endmodule

// File: tb/tb_maze_score_keeper.sv
// Self-checking bench for maze_score_keeper: directed rounds with literal expectations,
// then random play, all compared each cycle against an integer-level round model.
module tb_maze_score_keeper;
    localparam int DIV_A  = 10;
    localparam int DIV_B  = 2;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_COMMIT = 2;
    localparam int M_HOLD = 3;

    logic clk;
    logic rst_sys;
    int   checks;
    int   errors;
    bit   cmp_en;

    maze_score_keeper_if bus ();
    maze_score_keeper_if bus2 ();

    assign bus2.state   = bus.state;
    assign bus2.level   = bus.level;
    assign bus2.x_index = bus.x_index;
    assign bus2.y_index = bus.y_index;
    assign bus2.arrived = bus.arrived;

    maze_score_keeper #(.TICK_DIV(DIV_A), .LEVELS(8)) dut (
        .clk     (clk),
        .rst_sys (rst_sys),
        .bus     (bus)
    );

    maze_score_keeper #(.TICK_DIV(DIV_B), .LEVELS(8)) dut_fast (
        .clk     (clk),
        .rst_sys (rst_sys),
        .bus     (bus2)
    );

    always #5 clk = ~clk;

    // Round model: plain integer counts, seconds derived from elapsed RUN cycles.
    int m_mode;
    int m_steps;
    int m_ticks;
    int m_lvl;
    int m_prev_x;
    int m_prev_y;
    bit m_arr_prev;
    bit m_new_rec;
    int m_best [8];

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or posedge rst_sys) begin : model
        int  n_mode;
        bit  start;
        bit  rise;
        if (rst_sys) begin
            m_mode     <= M_IDLE;
            m_steps    <= 0;
            m_ticks    <= 0;
            m_lvl      <= 0;
            m_prev_x   <= 0;
            m_prev_y   <= 0;
            m_arr_prev <= 1'b0;
            m_new_rec  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_best[i] <= -1;
            end
        end else begin
            n_mode = m_mode;
            start  = 1'b0;
            rise   = bus.arrived && !m_arr_prev;
            case (m_mode)
                M_IDLE: start = (bus.state == 2'b01);
                M_RUN: begin
                    if (int'(bus.x_index) != m_prev_x || int'(bus.y_index) != m_prev_y) begin
                        m_steps  <= m_steps + 1;
                        m_prev_x <= int'(bus.x_index);
                        m_prev_y <= int'(bus.y_index);
                    end
                    m_ticks <= m_ticks + 1;
                    if (rise)
                        n_mode = M_COMMIT;
                    else if (bus.state != 2'b01)
                        n_mode = M_IDLE;
                end
                M_COMMIT: begin
                    if (m_best[m_lvl] < 0 || sat(m_steps) < m_best[m_lvl]) begin
                        m_best[m_lvl] <= sat(m_steps);
                        m_new_rec     <= 1'b1;
                    end
                    n_mode = M_HOLD;
                end
                default: begin
                    if (bus.state == 2'b01)
                        start = 1'b1;
                    else if (bus.state != 2'b10)
                        n_mode = M_IDLE;
                end
            endcase
            if (start) begin
                n_mode = M_RUN;
                m_steps   <= 0;
                m_ticks   <= 0;
                m_new_rec <= 1'b0;
                m_lvl     <= int'(bus.level);
                m_prev_x  <= int'(bus.x_index);
                m_prev_y  <= int'(bus.y_index);
            end
            m_mode     <= n_mode;
            m_arr_prev <= bus.arrived;
        end
    end

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_best(input logic [2:0] lv);
        return (m_best[lv] < 0) ? 16'h0000 : to_bcd(m_best[lv]);
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("steps",       bus.steps_bcd,          to_bcd(sat(m_steps)));
            check_output("secs",        bus.secs_bcd,           to_bcd(sat(m_ticks / DIV_A)));
            check_output("new_record",  {15'b0, bus.new_record}, {15'b0, m_new_rec});
            check_output("running",     {15'b0, bus.running},    {15'b0, m_mode == M_RUN});
            check_output("best",        bus.best_bcd,           model_best(bus.level));
            check_output("fast_steps",  bus2.steps_bcd,         to_bcd(sat(m_steps)));
            check_output("fast_secs",   bus2.secs_bcd,          to_bcd(sat(m_ticks / DIV_B)));
            check_output("fast_best",   bus2.best_bcd,          model_best(bus.level));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus_move();
        bus.x_index = bus.x_index + 5'd1;
        cyc(1);
    endtask

    task automatic apply_stimulus_round(input logic [2:0] lv, input int moves);
        bus.level = lv;
        bus.state = 2'b01;
        cyc(1);
        for (int i = 0; i < moves; i++) apply_stimulus_move();
    endtask

    task automatic apply_stimulus_finish();
        bus.arrived = 1'b1;
        cyc(2);
    endtask

    task automatic apply_stimulus_menu();
        bus.arrived = 1'b0;
        bus.state   = 2'b00;
        cyc(1);
    endtask

    initial begin
        clk = 1'b0;
        rst_sys = 1'b1;
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        bus.state = 2'b00;
        bus.level = 3'd0;
        bus.x_index = 5'd0;
        bus.y_index = 5'd0;
        bus.arrived = 1'b0;
        cyc(2);
        check_output("reset steps", bus.steps_bcd, 16'h0000);
        check_output("reset secs", bus.secs_bcd, 16'h0000);
        check_output("reset new_record", {15'b0, bus.new_record}, 16'h0000);
        check_output("reset running", {15'b0, bus.running}, 16'h0000);
        check_output("reset best", bus.best_bcd, 16'h0000);
        rst_sys = 1'b0;
        cmp_en  = 1'b1;
        cyc(1);

        $display("[TB] first win on level 2");
        apply_stimulus_round(3'd2, 3);
        check_output("t1 running", {15'b0, bus.running}, 16'h0001);
        apply_stimulus_finish();
        check_output("t1 steps", bus.steps_bcd, 16'h0003);
        check_output("t1 new_record", {15'b0, bus.new_record}, 16'h0001);
        check_output("t1 best", bus.best_bcd, 16'h0003);
        check_output("t1 model best", model_best(3'd2), 16'h0003);
        apply_stimulus_menu();

        $display("[TB] worse round, then better round");
        apply_stimulus_round(3'd2, 5);
        apply_stimulus_finish();
        check_output("t3 worse new_record", {15'b0, bus.new_record}, 16'h0000);
        check_output("t3 worse best", bus.best_bcd, 16'h0003);
        apply_stimulus_menu();
        apply_stimulus_round(3'd2, 2);
        apply_stimulus_finish();
        check_output("t3 better best", bus.best_bcd, 16'h0002);
        check_output("t3 better new_record", {15'b0, bus.new_record}, 16'h0001);
        apply_stimulus_menu();

        $display("[TB] abandoned round");
        apply_stimulus_round(3'd2, 10);
        bus.state = 2'b00;
        cyc(1);
        check_output("t4 running", {15'b0, bus.running}, 16'h0000);
        check_output("t4 steps", bus.steps_bcd, 16'h0010);
        check_output("t4 new_record", {15'b0, bus.new_record}, 16'h0000);
        check_output("t4 best", bus.best_bcd, 16'h0002);

        $display("[TB] step and arrival in the same cycle");
        apply_stimulus_round(3'd5, 8);
        bus.x_index = bus.x_index + 5'd1;
        bus.arrived = 1'b1;
        cyc(2);
        check_output("t5 steps", bus.steps_bcd, 16'h0009);
        check_output("t5 best", bus.best_bcd, 16'h0009);
        check_output("t5 new_record", {15'b0, bus.new_record}, 16'h0001);
        apply_stimulus_menu();

        $display("[TB] long round, counter saturation");
        apply_stimulus_round(3'd1, 0);
        cyc(125);
        check_output("t2 secs 125", bus.secs_bcd, 16'h0012);
        check_output("t2 fast secs 125", bus2.secs_bcd, 16'h0062);
        for (int i = 0; i < 20000; i++) apply_stimulus_move();
        cyc(50);
        check_output("t2 steps sat", bus.steps_bcd, 16'h9999);
        check_output("t2 secs", bus.secs_bcd, 16'h2017);
        check_output("t2 fast secs sat", bus2.secs_bcd, 16'h9999);
        apply_stimulus_menu();

        $display("[TB] asynchronous reset mid-round");
        apply_stimulus_round(3'd2, 4);
        #2;
        rst_sys = 1'b1;
        #1;
        check_output("t6 steps", bus.steps_bcd, 16'h0000);
        check_output("t6 secs", bus.secs_bcd, 16'h0000);
        check_output("t6 new_record", {15'b0, bus.new_record}, 16'h0000);
        check_output("t6 running", {15'b0, bus.running}, 16'h0000);
        for (int lv = 0; lv < 8; lv++) begin
            bus.level = 3'(lv);
            #1;
            check_output("t6 best", bus.best_bcd, 16'h0000);
        end
        bus.state = 2'b00;
        cyc(1);
        rst_sys = 1'b0;
        cyc(1);

        $display("[TB] random play");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 88)
                bus.state = 2'b01;
            else
                bus.state = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) bus.arrived = ~bus.arrived;
            if ($urandom_range(0, 2) == 0) begin
                bus.x_index = 5'($urandom);
                bus.y_index = 5'($urandom);
            end
            if ($urandom_range(0, 49) == 0) bus.level = 3'($urandom);
            cyc(1);
        end

        cyc(2);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/maze_score_keeper.md
# maze_score_keeper

Scoring stage downstream of the player-movement and game-FSM logic in the maze game. While a round is in play it counts player steps and elapsed seconds in BCD. When the player arrives at the exit it commits a per-level best step count and flags a new record. Its BCD outputs feed the 7-segment and serial-segment display drivers.

## Interface

Parameters:
- TICK_DIV, 100_000_000: clk cycles per counted second (≥2).
- LEVELS, 8: number of best-score entries; indexed by `level`.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst_sys  in  1  reset; asynchronous, active-high.
- state  in  2  game state: 2'b00 menu, 2'b01 playing, 2'b10 won; other codes are treated as menu.
- level  in  3  current level index; sampled at round start.
- x_index  in  5  player column from movement logic.
- y_index  in  5  player row from movement logic.
- arrived  in  1  level-high while the player is on the exit cell.
- steps_bcd  out  16  steps this round, 4 BCD digits.
- secs_bcd  out  16  seconds this round, 4 BCD digits.
- best_bcd  out  16  best steps stored for `level`; 16'h0000 if no best is recorded.
- new_record  out  1  high from commit until the next round start when the round beat the stored best (or no best was recorded).
- running  out  1  high in RUN.

## Operation

- FSM states:
  - IDLE: reset state.
  - RUN
  - COMMIT: exactly one cycle.
  - HOLD
- IDLE→RUN when `state==2'b01`. On entry:
  - clear steps, secs and the tick counter;
  - clear new_record;
  - latch `level` into lvl_r;
  - latch x_index/y_index into prev_x/prev_y.
- RUN:
  - Step counting: each cycle where {x_index,y_index} != {prev_x,prev_y}, increment steps and update prev.
  - Multi-cell jumps count as one step.
  - Second counting: the tick counter counts 0..TICK_DIV-1; on wrap, increment secs.
  - Both counters are 4-digit BCD. Each digit carries at 9→0. Counters saturate at 9999 and do not wrap.
- RUN exits:
  - Rising edge of `arrived` (registered compare): go to COMMIT.
  - Otherwise, if `state!=2'b01`: go to IDLE. The round is abandoned, no commit is made, and steps/secs keep their last values.
  - If arrived rises in the same cycle as a position change, the step is counted before the commit.
- COMMIT:
  - best table: LEVELS entries of 16-bit BCD plus a valid bit each.
  - If the entry is invalid or steps < best[lvl_r] (BCD compare is equivalent to unsigned compare): write steps, set valid, set new_record.
  - Equal counts are not a record.
  - Then go to HOLD.
- HOLD:
  - Counters are frozen.
  - `state==2'b00` → IDLE.
  - `state==2'b01` → RUN, with the same entry actions as IDLE→RUN.
- best_bcd is a combinational read of entry `level` (the live input, not lvl_r). It returns 0 when the entry is invalid.
- The best table and valid bits survive round changes. They are cleared only by rst_sys.

## Timing

- Reset values:
  - FSM in IDLE;
  - steps_bcd, secs_bcd = 0;
  - new_record = 0, running = 0;
  - all valid bits = 0, so best_bcd = 0;
  - tick counter = 0.
- All outputs except best_bcd are registered.
- Step latency: a position change at cycle n appears in steps_bcd at n+1.
- First second: secs_bcd becomes 0001 TICK_DIV cycles after RUN entry.
- Arrived latency: the arrived rise seen at cycle n puts the FSM in COMMIT at n+1; new_record and the table update are visible at n+2.
- arrived already high on RUN entry gives no rising edge. The edge detector is initialised to the current arrived value at entry.
- rst_sys asserted mid-round takes effect immediately (async): everything returns to reset values, including the table.

## Test plan

1. Reset, then `state=01`, then 3 position changes on separate cycles, then arrived=1 → steps_bcd=0003, new_record=1, best_bcd=0003 for that level.
2. TICK_DIV=10, remain in RUN for 125 cycles → secs_bcd=0012; after 9999 seconds, secs_bcd holds 9999.
3. Second round on the same level with 5 steps → new_record=0 and best stays 0003. Third round with 2 steps → best=0002 and new_record=1.
4. 10 steps then `state→00` without arrived → FSM in IDLE, best unchanged, new_record=0, steps_bcd=0010.
5. Position change and arrived rise in the same cycle after 8 steps → steps_bcd=0009 and 0009 is committed.
6. Assert rst_sys mid-RUN with best entries stored → all outputs 0 and best_bcd=0000 for every level.
